pipelined_shifter: RTL and testbench
====================================

Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter for the structural ALU; next generation of the fixed 32-bit logical-right shifter.
- Adds configurable width, five shift/rotate modes, an optional mid-pipeline register and a valid/ready handshake on input and output.
- Datapath is a log2(WIDTH)-level 2:1 mux ladder built from the team mux cell; sits between operand fetch and ALU result select.

Parameters:
- WIDTH, 32, data width; power of two, >= 4.
- SPLIT, 1, 0 = single register stage (latency 1); 1 = extra register after mux level floor(log2(WIDTH)/2)-1 (latency 2).
- SHW (localparam), log2(WIDTH), shift-amount width.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept request this cycle
- operand_a  input  WIDTH  value to shift
- operand_b  input  WIDTH  shift amount; only bits [SHW-1:0] used, upper bits ignored
- op  input  3  mode: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- shift_res  output  WIDTH  result
- res_zero  output  1  shift_res == 0
- illegal_op  output  1  op of the held result was 101-111

Behaviour:
- Reset (async assert, sync deassert handled by the top level): all stage valid bits = 0; shift_res, res_zero, illegal_op = 0; out_valid = 0; in_ready = 1 (combinational from empty state).
- Accept: transfer when in_valid && in_ready on a rising edge. Output: transfer when out_valid && out_ready.
- Pipeline: SPLIT+1 register stages, each with its own valid bit. Stage k loads when it is empty or stage k+1 accepts/drains this cycle. Last stage drains on out_ready.
- in_ready = !v0 || (stage 0 advances this cycle); combinational, no bubbles. Full throughput of one result per cycle when out_ready is held high.
- Latency: result appears on out_valid exactly SPLIT+1 cycles after acceptance, absent backpressure.
- Stall: while out_valid && !out_ready, shift_res, res_zero and illegal_op hold stable. Upstream stages fill, then in_ready drops. No data is lost or duplicated.
- Arithmetic, with s = operand_b[SHW-1:0]:
  - SLL: a << s, zero fill.
  - SRL: a >> s, zero fill.
  - SRA: a >> s, fill with a[WIDTH-1].
  - ROL / ROR: rotate by s mod WIDTH.
  - s = 0 returns a unchanged in every mode.
- Illegal op: shift_res = operand_a unmodified, illegal_op = 1, handshake unaffected.
- Mux ladder: level j shifts by 2^j under s[j]. Left modes are implemented by bit-reversing input and output around the right-shift ladder. Fill bit per level = 0, sign bit, or wrapped bits depending on mode.
- res_zero is computed from the final mux-level result and registered alongside shift_res.
- Reset mid-operation: all in-flight results are discarded and valids clear immediately. The first post-reset request behaves as from idle.
- Simultaneous accept and drain with the pipeline full: both occur and occupancy is unchanged.

Test Plan:
- Reset with rst_n low mid-stream, valids previously set -> out_valid = 0 and in_ready = 1 asynchronously. Next request completes after SPLIT+1 cycles.
- WIDTH=32, SPLIT=1, a=0x8000_00F0, b=4, each op 000-100 -> SLL 0x0000_0F00, SRL 0x0800_000F, SRA 0xF800_000F, ROL 0x0000_0F08, ROR 0x0800_000F. out_valid appears 2 cycles after accept.
- a=0xDEAD_BEEF, b=0xFFFF_FFE0 (s = 0), all modes -> 0xDEAD_BEEF. Then b=31 with SRA -> 0xFFFF_FFFF, with SRL -> 0x0000_0001.
- op=110, a=0x1234_5678 -> shift_res 0x1234_5678, illegal_op = 1. SLL of a=1 by 32 (s = 0) -> 1, res_zero = 0. SRL of a=1 by 1 -> 0, res_zero = 1.
- Back-to-back 16 requests with out_ready held 0 for 5 cycles mid-burst -> in_ready drops once stages fill. Result order and values match a scoreboard, with no drops or duplicates. Throughput returns to 1 per cycle after release.
- Random op, a and b, repeated for WIDTH=8 and 64 with SPLIT=0 and SPLIT=1, using random in_valid/out_ready -> every result matches the reference model, and latency equals SPLIT+1 whenever there is no stall.

Source files
------------

// File: rtl/pipelined_shifter_if.sv
// pipelined_shifter_if: request/result handshake bundle for pipelined_shifter
//   request : in_valid/in_ready, operand_a (value), operand_b (amount), op (mode)
//   result  : out_valid/out_ready, shift_res, res_zero, illegal_op
//   master = producer/consumer side, slave = shifter side
interface pipelined_shifter_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] shift_res;
   logic             res_zero;
   logic             illegal_op;
   modport master (
      output in_valid, operand_a, operand_b, op, out_ready,
      input  in_ready, out_valid, shift_res, res_zero, illegal_op
   );
   modport slave (
      input  in_valid, operand_a, operand_b, op, out_ready,
      output in_ready, out_valid, shift_res, res_zero, illegal_op
   );
endinterface

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready flow control
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_shifter_if (request in, result out)
module pipelined_shifter #(
   parameter int WIDTH = 32,
   parameter int SPLIT = 1
) (
   input logic                clk,
   input logic                rst_n,
   pipelined_shifter_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int MID = SHW / 2;
   localparam int LO = SPLIT != 0 ? MID : 0;
   typedef logic [WIDTH-1:0] word_t;
   typedef logic [SHW-1:0] amt_t;
   function automatic word_t rev(input word_t x);
      word_t r;
      for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
      return r;
   endfunction
   // Right-shift ladder levels lo..hi-1; level j moves by 2^j and fills with zeros, the sign or the wrapped bits
   function automatic word_t ladder(input word_t x, input amt_t s, input logic rot, input logic sgn,
                                    input int lo, input int hi);
      word_t y;
      y = x;
      for (int j = 0; j < SHW; j++)
         if (j >= lo && j < hi && s[j])
            y = (y >> (1 << j)) | (rot ? y << (WIDTH - (1 << j)) : sgn ? ~({WIDTH{1'b1}} >> (1 << j)) : '0);
      return y;
   endfunction
   logic  ill, left, rot, sgn, unused_b;
   amt_t  amt;
   word_t src;
   // Left modes run through the right ladder on a bit-reversed operand; illegal ops pass through with amount 0
   always_comb begin
      ill = bus.op > 3'd4;
      left = bus.op == 3'd0 || bus.op == 3'd3;
      rot = bus.op == 3'd3 || bus.op == 3'd4;
      sgn = bus.op == 3'd2 && bus.operand_a[WIDTH-1];
      amt = ill ? '0 : bus.operand_b[SHW-1:0];
      src = left ? rev(bus.operand_a) : bus.operand_a;
   end
   assign unused_b = ^bus.operand_b[WIDTH-1:SHW];
   logic  out_v, take, res_zero_r, illegal_r;
   word_t res_r, fin_x, lad, fin_y;
   amt_t  fin_s;
   logic  fin_rot, fin_sgn, fin_left, fin_ill, fin_v;
   assign take = !out_v || bus.out_ready;
   generate
      if (SPLIT != 0) begin : g_split
         logic  v0, m_rot, m_sgn, m_left, m_ill;
         word_t m_x;
         amt_t  m_s;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) v0 <= 1'b0;
            else if (bus.in_ready) v0 <= bus.in_valid;
         always_ff @(posedge clk)
            if (bus.in_ready && bus.in_valid) begin
               m_x <= ladder(src, amt, rot, sgn, 0, MID);
               m_s <= amt;
               m_rot <= rot;
               m_sgn <= sgn;
               m_left <= left;
               m_ill <= ill;
            end
         assign bus.in_ready = !v0 || take;
         assign {fin_x, fin_s, fin_rot, fin_sgn, fin_left, fin_ill, fin_v} = {m_x, m_s, m_rot, m_sgn, m_left, m_ill, v0};
      end else begin : g_single
         assign bus.in_ready = take;
         assign {fin_x, fin_s, fin_rot, fin_sgn, fin_left, fin_ill, fin_v} = {src, amt, rot, sgn, left, ill, bus.in_valid};
      end
   endgenerate
   assign lad = ladder(fin_x, fin_s, fin_rot, fin_sgn, LO, SHW);
   assign fin_y = fin_left ? rev(lad) : lad;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_v <= 1'b0;
         res_r <= '0;
         res_zero_r <= 1'b0;
         illegal_r <= 1'b0;
      end else if (take) begin
         out_v <= fin_v;
         if (fin_v) begin
            res_r <= fin_y;
            res_zero_r <= fin_y == '0;
            illegal_r <= fin_ill;
         end
      end
   assign bus.out_valid = out_v;
   assign bus.shift_res = res_r;
   assign bus.res_zero = res_zero_r;
   assign bus.illegal_op = illegal_r;
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb_pipelined_shifter: directed and randomized checks of pipelined_shifter against a bit-level reference model
module tb_pipelined_shifter;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   initial forever #5 clk = ~clk;

   pipelined_shifter_if #(.WIDTH(32)) m ();
   pipelined_shifter #(.WIDTH(32), .SPLIT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(m));

   logic        rv_in_valid [4];
   logic        rv_out_ready[4];
   logic [63:0] rv_a[4], rv_b[4], r_res[4];
   logic [2:0]  rv_op[4];
   logic        r_in_ready[4], r_out_valid[4], r_zero[4], r_ill[4];

   for (genvar g = 0; g < 4; g++) begin : g_cfg
      localparam int W = g < 2 ? 8 : 64;
      pipelined_shifter_if #(.WIDTH(W)) bus ();
      pipelined_shifter #(.WIDTH(W), .SPLIT(g % 2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
      assign bus.in_valid = rv_in_valid[g];
      assign bus.out_ready = rv_out_ready[g];
      assign bus.operand_a = rv_a[g][W-1:0];
      assign bus.operand_b = rv_b[g][W-1:0];
      assign bus.op = rv_op[g];
      assign r_in_ready[g] = bus.in_ready;
      assign r_out_valid[g] = bus.out_valid;
      assign r_res[g] = 64'(bus.shift_res);
      assign r_zero[g] = bus.res_zero;
      assign r_ill[g] = bus.illegal_op;
   end

   // Reference: each result bit is picked straight from the operand by the mode's definition
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input int w);
      logic [63:0] r;
      int s;
      s = int'(b % 64'(w));
      r = '0;
      for (int i = 0; i < w; i++)
         case (op)
            3'd0: r[i] = i >= s ? a[i-s] : 1'b0;
            3'd1: r[i] = i + s < w ? a[i+s] : 1'b0;
            3'd2: r[i] = i + s < w ? a[i+s] : a[w-1];
            3'd3: r[i] = a[(i - s + w) % w];
            3'd4: r[i] = a[(i + s) % w];
            default: r[i] = a[i];
         endcase
      return r;
   endfunction

   task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                          output logic [31:0] r, output logic z, output logic il, output int lat);
      @(negedge clk);
      m.in_valid = 1'b1;
      m.operand_a = a;
      m.operand_b = b;
      m.op = o;
      m.out_ready = 1'b1;
      @(negedge clk);
      m.in_valid = 1'b0;
      lat = 1;
      while (!m.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      r = m.shift_res;
      z = m.res_zero;
      il = m.illegal_op;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      logic z, il;
      int lat;
      total++;
      if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle out_valid=%b in_ready=%b expected 0/1", m.out_valid, m.in_ready);
      end
      total++;
      if ({m.shift_res, m.res_zero, m.illegal_op} !== 34'd0) begin
         bad++;
         $display("FAIL reset_outputs res=%h zero=%b ill=%b expected 0", m.shift_res, m.res_zero, m.illegal_op);
      end
      @(negedge clk);
      m.out_ready = 1'b0;
      m.in_valid = 1'b1;
      m.operand_a = 32'h0000_00F0;
      m.operand_b = 32'd1;
      m.op = 3'd1;
      @(negedge clk);
      @(negedge clk);
      m.in_valid = 1'b0;
      #2;
      total++;
      if (m.out_valid !== 1'b1 || m.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_prefill out_valid=%b in_ready=%b expected 1/0", m.out_valid, m.in_ready);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (m.out_valid !== 1'b0 || m.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_async out_valid=%b in_ready=%b expected 0/1", m.out_valid, m.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_one(32'h0000_00F0, 32'd4, 3'd0, r, z, il, lat);
      total++;
      if (r !== 32'h0000_0F00 || lat != 2) begin
         bad++;
         $display("FAIL reset_first res=%h lat=%0d expected 00000f00 lat=2", r, lat);
      end
   endtask

   task automatic test_modes();
      logic [31:0] exp_t [5] = '{32'h0000_0F00, 32'h0800_000F, 32'hF800_000F, 32'h0000_0F08, 32'h0800_000F};
      logic [31:0] r;
      logic z, il;
      int lat;
      for (int o = 0; o < 5; o++) begin
         run_one(32'h8000_00F0, 32'd4, 3'(o), r, z, il, lat);
         total++;
         if (r !== exp_t[o] || il !== 1'b0) begin
            bad++;
            $display("FAIL modes op=%0d res=%h ill=%b expected %h ill=0", o, r, il, exp_t[o]);
         end
         total++;
         if (lat != 2) begin
            bad++;
            $display("FAIL modes_latency op=%0d got=%0d expected 2", o, lat);
         end
      end
   endtask

   task automatic test_zero_shift();
      logic [31:0] r;
      logic z, il;
      int lat;
      for (int o = 0; o < 5; o++) begin
         run_one(32'hDEAD_BEEF, 32'hFFFF_FFE0, 3'(o), r, z, il, lat);
         total++;
         if (r !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL zero_shift op=%0d res=%h expected deadbeef", o, r);
         end
      end
      run_one(32'hDEAD_BEEF, 32'd31, 3'd2, r, z, il, lat);
      total++;
      if (r !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL sra31 res=%h expected ffffffff", r);
      end
      run_one(32'hDEAD_BEEF, 32'd31, 3'd1, r, z, il, lat);
      total++;
      if (r !== 32'h0000_0001) begin
         bad++;
         $display("FAIL srl31 res=%h expected 00000001", r);
      end
   endtask

   task automatic test_flags();
      logic [31:0] r;
      logic z, il;
      int lat;
      run_one(32'h1234_5678, 32'd5, 3'd6, r, z, il, lat);
      total++;
      if ({r, z, il} !== {32'h1234_5678, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL illegal res=%h zero=%b ill=%b expected 12345678/0/1", r, z, il);
      end
      run_one(32'd1, 32'd32, 3'd0, r, z, il, lat);
      total++;
      if ({r, z, il} !== {32'd1, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL sll32 res=%h zero=%b ill=%b expected 00000001/0/0", r, z, il);
      end
      run_one(32'd1, 32'd1, 3'd1, r, z, il, lat);
      total++;
      if ({r, z, il} !== {32'd0, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL zero_flag res=%h zero=%b ill=%b expected 00000000/1/0", r, z, il);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] q[$];
      logic [31:0] a, b;
      logic [2:0]  o;
      int   sent = 0, got = 0, gap = 0;
      logic blocked = 1'b0;
      for (int c = 0; c < 60 && got < 16; c++) begin
         @(negedge clk);
         a = $urandom;
         b = $urandom;
         o = 3'($urandom_range(0, 4));
         m.in_valid = sent < 16;
         m.operand_a = a;
         m.operand_b = b;
         m.op = o;
         m.out_ready = !(c >= 4 && c < 9);
         #1;
         if (c >= 4 && c < 9 && !m.in_ready) blocked = 1'b1;
         if (m.out_valid) begin
            total++;
            if (q.size() == 0 || m.shift_res !== q[0]) begin
               bad++;
               $display("FAIL b2b_data c=%0d got=%h expected=%h pending=%0d", c, m.shift_res,
                        q.size() != 0 ? q[0] : 32'hx, q.size());
            end
            if (m.out_ready) begin
               if (q.size() != 0) void'(q.pop_front());
               got++;
            end
         end
         if (c >= 9 && !(m.out_valid && m.out_ready)) gap++;
         if (m.in_valid && m.in_ready) begin
            q.push_back(32'(model(64'(a), 64'(b), o, 32)));
            sent++;
         end
      end
      m.in_valid = 1'b0;
      total++;
      if (got != 16 || sent != 16) begin
         bad++;
         $display("FAIL b2b_count got=%0d sent=%0d expected 16/16", got, sent);
      end
      total++;
      if (gap != 0) begin
         bad++;
         $display("FAIL b2b_throughput idle_cycles=%0d expected 0", gap);
      end
      total++;
      if (!blocked) begin
         bad++;
         $display("FAIL b2b_backpressure in_ready_dropped=%b expected 1", blocked);
      end
   endtask

   task automatic test_random(input int g, input int w, input int s);
      logic [63:0] exp_q[$];
      logic        ill_q[$];
      int          acc_q[$];
      int   app = 0, t;
      logic held = 1'b0, ei;
      logic [63:0] e;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         rv_in_valid[g] = c < 300 && $urandom_range(0, 3) != 0;
         rv_out_ready[g] = c < 100 || c >= 300 || $urandom_range(0, 3) != 0;
         rv_a[g] = {$urandom, $urandom};
         rv_b[g] = {$urandom, $urandom};
         rv_op[g] = 3'($urandom_range(0, 7));
         #1;
         if (r_out_valid[g]) begin
            if (!held) app = c;
            if (rv_out_ready[g]) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL rand_extra w=%0d split=%0d c=%0d got=%h expected no result", w, s, c, r_res[g]);
               end else begin
                  e = exp_q.pop_front();
                  ei = ill_q.pop_front();
                  t = acc_q.pop_front();
                  if ({r_res[g], r_zero[g], r_ill[g]} !== {e, e == 64'd0, ei}) begin
                     bad++;
                     $display("FAIL rand_data w=%0d split=%0d c=%0d got=%h/%b/%b expected=%h/%b/%b",
                              w, s, c, r_res[g], r_zero[g], r_ill[g], e, e == 64'd0, ei);
                  end
                  total++;
                  if (app < 100 ? app - t != s + 1 : app - t < s + 1) begin
                     bad++;
                     $display("FAIL rand_latency w=%0d split=%0d got=%0d expected %0d", w, s, app - t, s + 1);
                  end
               end
            end
         end
         held = r_out_valid[g] && !rv_out_ready[g];
         if (rv_in_valid[g] && r_in_ready[g]) begin
            exp_q.push_back(model(rv_a[g], rv_b[g], rv_op[g], w));
            ill_q.push_back(rv_op[g] > 3'd4);
            acc_q.push_back(c);
         end
      end
      rv_in_valid[g] = 1'b0;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rand_lost w=%0d split=%0d missing=%0d expected 0", w, s, exp_q.size());
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m.in_valid = 1'b0;
      m.out_ready = 1'b1;
      m.operand_a = '0;
      m.operand_b = '0;
      m.op = '0;
      for (int g = 0; g < 4; g++) begin
         rv_in_valid[g] = 1'b0;
         rv_out_ready[g] = 1'b1;
         rv_a[g] = '0;
         rv_b[g] = '0;
         rv_op[g] = '0;
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_modes();
      test_zero_shift();
      test_flags();
      test_back_to_back();
      for (int g = 0; g < 4; g++) test_random(g, g < 2 ? 8 : 64, g % 2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
